vic_param: RTL and testbench

- Parametrised vectored interrupt controller; successor to the fixed 32-source, 16-slot VIC.
- Sits between peripheral interrupt lines and the core's nIRQ/nFIQ inputs. Memory-mapped on the system bus at ADDR_BASE.
- Adds the following:
  - source synchronisation
  - per-source edge/level mode
  - registered bus reads
  - hardware priority masking with an in-service stack: acknowledge on VectAddr read, end-of-interrupt (EOI) on VectAddr write.

---
 rtl/vic_param.sv | 200 ++++++++++++++++++++
 tb/tb_vic_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vic_param.sv
// rtl/vic_param.sv - parametrised vectored interrupt controller with in-service priority stack
//
// Ports:
//   clk             system clock, rising-edge
//   rst             asynchronous active-low reset
//   VICFIQEn        enables the nVICFIQ output
//   VICIRQEn        enables the nVICIRQ output
//   vic_intrsource  raw asynchronous interrupt lines (NUM_SRC)
//   bus_addr        byte address; selected when [31:12] matches ADDR_BASE
//   bus_wr          1 = write, 0 = read
//   bus_en          one-cycle access strobe
//   bus_data_i      write data
//   bus_data_o      registered read data, valid the cycle after the read strobe
//   nVICFIQ         registered active-low FIQ request
//   nVICIRQ         registered active-low IRQ request
//   VICVectAddrOut  registered vector of the highest eligible request
module vic_param #(
    parameter int          NUM_SRC   = 32,
    parameter int          NUM_VECT  = 16,
    parameter logic [31:0] ADDR_BASE = 32'hFFFFF000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               VICFIQEn,
    input  logic               VICIRQEn,
    input  logic [NUM_SRC-1:0] vic_intrsource,
    input  logic [31:0]        bus_addr,
    input  logic               bus_wr,
    input  logic               bus_en,
    input  logic [31:0]        bus_data_i,
    output logic [31:0]        bus_data_o,
    output logic               nVICFIQ,
    output logic               nVICIRQ,
    output logic [31:0]        VICVectAddrOut
);

    logic [NUM_SRC-1:0] s1, s2, s3, edgeLatch;
    logic [NUM_SRC-1:0] intSelect, intEnable, softInt, intMode;
    logic [31:0]        defVectAddr;
    logic [31:0]        vectAddr [NUM_VECT];
    logic [5:0]         vectCntl [NUM_VECT];
    logic [NUM_VECT:0]  inService;

    logic [NUM_SRC-1:0] pend, rawIntr, fiqStatus, irqStatus, claimed, wd, edgeClr;
    logic [NUM_VECT:0]  req, wOneHot;
    logic               wFound;
    logic [31:0]        wVect;
    logic               sel, wrEn, rdEn, ackRd, eoiWr;
    logic [9:0]         wordIdx;
    logic [31:0]        rdData;
    logic               unusedAddrBits;

    assign unusedAddrBits = ^bus_addr[1:0];

    // Bus decode; offsets are handled as word indices.
    always_comb begin
        sel     = (bus_addr[31:12] == ADDR_BASE[31:12]);
        wordIdx = bus_addr[11:2];
        wrEn    = bus_en & bus_wr & sel;
        rdEn    = bus_en & ~bus_wr;
        ackRd   = rdEn & sel & (wordIdx == 10'h00C);
        eoiWr   = wrEn & (wordIdx == 10'h00C);
        wd      = bus_data_i[NUM_SRC-1:0];
        edgeClr = (wrEn && wordIdx == 10'h00A) ? wd : '0;
    end

    always_comb begin
        pend      = (intMode & edgeLatch) | (~intMode & s2);
        rawIntr   = pend | softInt;
        fiqStatus = rawIntr & intEnable & intSelect;
        irqStatus = rawIntr & intEnable & ~intSelect;
    end

    // Slot requests; sources owned by any enabled slot are excluded from the
    // non-vectored pseudo-slot, even if that slot is currently masked.
    always_comb begin
        logic [31:0] irq32;
        logic [31:0] claim32;
        irq32   = 32'(irqStatus);
        claim32 = '0;
        req     = '0;
        for (int k = 0; k < NUM_VECT; k++) begin
            if (vectCntl[k][5] && (32'(vectCntl[k][4:0]) < NUM_SRC)) begin
                claim32[vectCntl[k][4:0]] = 1'b1;
                req[k] = irq32[vectCntl[k][4:0]];
            end
        end
        claimed       = claim32[NUM_SRC-1:0];
        req[NUM_VECT] = |(irqStatus & ~claimed);
    end

    // Winner search: a request is eligible only if it sits strictly above the
    // highest-priority slot already in service.
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        wFound  = 1'b0;
        wOneHot = '0;
        wVect   = '0;
        for (int j = 0; j < NUM_VECT; j++) begin
            if (inService[j]) blocked = 1'b1;
            if (!blocked && !wFound && req[j]) begin
                wFound     = 1'b1;
                wOneHot[j] = 1'b1;
                wVect      = vectAddr[j];
            end
        end
        if (inService[NUM_VECT]) blocked = 1'b1;
        if (!blocked && !wFound && req[NUM_VECT]) begin
            wFound            = 1'b1;
            wOneHot[NUM_VECT] = 1'b1;
            wVect             = defVectAddr;
        end
    end

    always_comb begin
        rdData = '0;
        if (sel) begin
            case (wordIdx)
                10'h000: rdData = 32'(irqStatus);
                10'h001: rdData = 32'(fiqStatus);
                10'h002: rdData = 32'(rawIntr);
                10'h003: rdData = 32'(intSelect);
                10'h004: rdData = 32'(intEnable);
                10'h006: rdData = 32'(softInt);
                10'h009: rdData = 32'(intMode);
                10'h00B: rdData = 32'(inService);
                10'h00C: rdData = wFound ? wVect : defVectAddr;
                10'h00D: rdData = defVectAddr;
                default: begin
                    for (int k = 0; k < NUM_VECT; k++) begin
                        if (wordIdx == 10'(10'h040 + k)) rdData = vectAddr[k];
                        if (wordIdx == 10'(10'h080 + k)) rdData = 32'(vectCntl[k]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1             <= '0;
            s2             <= '0;
            s3             <= '0;
            edgeLatch      <= '0;
            intSelect      <= '0;
            intEnable      <= '0;
            softInt        <= '0;
            intMode        <= '0;
            defVectAddr    <= '0;
            inService      <= '0;
            bus_data_o     <= '0;
            nVICFIQ        <= 1'b1;
            nVICIRQ        <= 1'b1;
            VICVectAddrOut <= '0;
            for (int k = 0; k < NUM_VECT; k++) begin
                vectAddr[k] <= '0;
                vectCntl[k] <= '0;
            end
        end else begin
            s1 <= vic_intrsource;
            s2 <= s1;
            s3 <= s2;
            // Set term is ORed last so a coincident edge survives EdgeClear.
            edgeLatch <= (edgeLatch & ~edgeClr) | (intMode & s2 & ~s3);

            if (wrEn) begin
                case (wordIdx)
                    10'h003: intSelect   <= wd;
                    10'h004: intEnable   <= intEnable | wd;
                    10'h005: intEnable   <= intEnable & ~wd;
                    10'h006: softInt     <= softInt | wd;
                    10'h007: softInt     <= softInt & ~wd;
                    10'h009: intMode     <= wd;
                    10'h00D: defVectAddr <= bus_data_i;
                    default: begin
                        for (int k = 0; k < NUM_VECT; k++) begin
                            if (wordIdx == 10'(10'h040 + k)) vectAddr[k] <= bus_data_i;
                            if (wordIdx == 10'(10'h080 + k)) vectCntl[k] <= bus_data_i[5:0];
                        end
                    end
                endcase
            end

            if (ackRd) begin
                inService <= inService | wOneHot;
            end else if (eoiWr) begin
                // Clear the lowest set bit, i.e. retire the highest-priority level.
                inService <= inService & (inService - {{NUM_VECT{1'b0}}, 1'b1});
            end

            if (rdEn) bus_data_o <= rdData;

            nVICFIQ        <= ~(VICFIQEn & (|fiqStatus));
            nVICIRQ        <= ~(VICIRQEn & wFound);
            VICVectAddrOut <= wFound ? wVect : '0;
        end
    end

endmodule

// File: tb/tb_vic_param.sv
// tb/tb_vic_param.sv - self-checking bench for vic_param
module tb_vic_param;

    localparam logic [31:0] BASE = 32'hFFFFF000;

    logic        clk = 1'b0;
    logic        rst;
    logic        VICFIQEn, VICIRQEn;
    logic [31:0] vic_intrsource;
    logic [31:0] bus_addr;
    logic        bus_wr, bus_en;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        nVICFIQ, nVICIRQ;
    logic [31:0] VICVectAddrOut;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rdItem_t;

    rdItem_t rdQ[$];
    logic    rdIssued = 1'b0;

    vic_param #(
        .NUM_SRC  (32),
        .NUM_VECT (16),
        .ADDR_BASE(BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .VICFIQEn      (VICFIQEn),
        .VICIRQEn      (VICIRQEn),
        .vic_intrsource(vic_intrsource),
        .bus_addr      (bus_addr),
        .bus_wr        (bus_wr),
        .bus_en        (bus_en),
        .bus_data_i    (bus_data_i),
        .bus_data_o    (bus_data_o),
        .nVICFIQ       (nVICFIQ),
        .nVICIRQ       (nVICIRQ),
        .VICVectAddrOut(VICVectAddrOut)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] regAddr(input logic [11:0] off);
        return BASE | 32'(off);
    endfunction

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        bus_addr   = addr;
        bus_data_i = data;
        bus_wr     = 1'b1;
        bus_en     = 1'b1;
        @(negedge clk);
        bus_en = 1'b0;
        bus_wr = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        rdItem_t it;
        it.tag = tag;
        it.exp = exp;
        rdQ.push_back(it);
        bus_addr = addr;
        bus_wr   = 1'b0;
        bus_en   = 1'b1;
        @(negedge clk);
        bus_en = 1'b0;
    endtask

    // Read scoreboard: data is due one cycle after the strobe edge.
    always @(posedge clk) rdIssued <= bus_en & ~bus_wr;

    always @(negedge clk) begin
        if (rdIssued) begin
            if (rdQ.size() == 0) begin
                checkVal("rdq_underflow", 32'(rdQ.size()), 32'd1);
            end else begin
                rdItem_t it;
                it = rdQ.pop_front();
                checkVal(it.tag, bus_data_o, it.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        VICFIQEn       = 1'b1;
        VICIRQEn       = 1'b1;
        vic_intrsource = '0;
        bus_addr       = '0;
        bus_wr         = 1'b0;
        bus_en         = 1'b0;
        bus_data_i     = '0;
        repeat (3) @(negedge clk);
        checkVal("rst_nirq", 32'(nVICIRQ), 32'd1);
        checkVal("rst_nfiq", 32'(nVICFIQ), 32'd1);
        checkVal("rst_vect", VICVectAddrOut, 32'd0);
        checkVal("rst_rdata", bus_data_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        busRead(regAddr(12'h008), 32'h0, "rst_raw");
        busRead(regAddr(12'h02C), 32'h0, "rst_insvc");
        busRead(regAddr(12'h030), 32'h0, "rst_vectaddr");
        checkVal("idle_nirq", 32'(nVICIRQ), 32'd1);
        checkVal("idle_nfiq", 32'(nVICFIQ), 32'd1);

        // Level request on slot 2 (source 5).
        busWrite(regAddr(12'h034), 32'hDEF0);
        busWrite(regAddr(12'h208), 32'h25);
        busWrite(regAddr(12'h108), 32'h1234);
        busWrite(regAddr(12'h010), 32'h20);
        vic_intrsource[5] = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("lvl_nirq_early", 32'(nVICIRQ), 32'd1);
        @(negedge clk);
        checkVal("lvl_nirq", 32'(nVICIRQ), 32'd0);
        checkVal("lvl_vectout", VICVectAddrOut, 32'h1234);
        busRead(regAddr(12'h030), 32'h1234, "lvl_ack");
        busRead(regAddr(12'h02C), 32'h4, "lvl_insvc");
        @(negedge clk);
        checkVal("lvl_masked", 32'(nVICIRQ), 32'd1);
        busWrite(regAddr(12'h030), 32'hFFFF_FFFF);
        busRead(regAddr(12'h02C), 32'h0, "lvl_eoi");
        vic_intrsource[5] = 1'b0;
        repeat (4) @(negedge clk);
        checkVal("lvl_drop", 32'(nVICIRQ), 32'd1);

        // Nesting: slot 3 in service, slot 1 preempts, slot 5 waits for both EOIs.
        busWrite(regAddr(12'h204), 32'h21);
        busWrite(regAddr(12'h104), 32'h1111);
        busWrite(regAddr(12'h20C), 32'h23);
        busWrite(regAddr(12'h10C), 32'h3333);
        busWrite(regAddr(12'h214), 32'h26);
        busWrite(regAddr(12'h114), 32'h5555);
        busWrite(regAddr(12'h010), 32'h4A);
        vic_intrsource[3] = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("nest_s3_nirq", 32'(nVICIRQ), 32'd0);
        checkVal("nest_s3_vect", VICVectAddrOut, 32'h3333);
        busRead(regAddr(12'h030), 32'h3333, "nest_ack3");
        busRead(regAddr(12'h02C), 32'h8, "nest_insvc3");
        vic_intrsource[6] = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("nest_s5_masked", 32'(nVICIRQ), 32'd1);
        vic_intrsource[1] = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("nest_s1_nirq", 32'(nVICIRQ), 32'd0);
        checkVal("nest_s1_vect", VICVectAddrOut, 32'h1111);
        busRead(regAddr(12'h030), 32'h1111, "nest_ack1");
        busRead(regAddr(12'h02C), 32'hA, "nest_insvcA");
        vic_intrsource[1] = 1'b0;
        vic_intrsource[3] = 1'b0;
        busWrite(regAddr(12'h030), 32'h0);
        busRead(regAddr(12'h02C), 32'h8, "nest_eoi1");
        repeat (3) @(negedge clk);
        checkVal("nest_s5_still_masked", 32'(nVICIRQ), 32'd1);
        busWrite(regAddr(12'h030), 32'h0);
        repeat (3) @(negedge clk);
        checkVal("nest_s5_nirq", 32'(nVICIRQ), 32'd0);
        checkVal("nest_s5_vect", VICVectAddrOut, 32'h5555);
        vic_intrsource[6] = 1'b0;
        repeat (4) @(negedge clk);
        checkVal("nest_deassert", 32'(nVICIRQ), 32'd1);
        checkVal("nest_deassert_vect", VICVectAddrOut, 32'h0);
        busRead(regAddr(12'h02C), 32'h0, "nest_insvc_empty");

        // Edge latching on source 7.
        busWrite(regAddr(12'h024), 32'h80);
        vic_intrsource[7] = 1'b1;
        @(negedge clk);
        vic_intrsource[7] = 1'b0;
        repeat (5) @(negedge clk);
        busRead(regAddr(12'h008), 32'h80, "edge_latched");
        repeat (5) @(negedge clk);
        busRead(regAddr(12'h008), 32'h80, "edge_hold");
        busWrite(regAddr(12'h028), 32'h80);
        busRead(regAddr(12'h008), 32'h0, "edge_cleared");
        vic_intrsource[7] = 1'b1;
        @(negedge clk);
        vic_intrsource[7] = 1'b0;
        @(negedge clk);
        busWrite(regAddr(12'h028), 32'h80);
        busRead(regAddr(12'h008), 32'h80, "edge_set_wins");
        busWrite(regAddr(12'h028), 32'h80);
        busWrite(regAddr(12'h024), 32'h0);
        busRead(regAddr(12'h008), 32'h0, "edge_tidy");

        // FIQ via soft interrupt 0.
        busWrite(regAddr(12'h00C), 32'h1);
        busWrite(regAddr(12'h010), 32'h1);
        busWrite(regAddr(12'h018), 32'h1);
        @(negedge clk);
        checkVal("fiq_nfiq", 32'(nVICFIQ), 32'd0);
        checkVal("fiq_nirq", 32'(nVICIRQ), 32'd1);
        busRead(regAddr(12'h004), 32'h1, "fiq_status");
        busRead(regAddr(12'h000), 32'h0, "fiq_irqstatus");
        busWrite(regAddr(12'h01C), 32'h1);
        checkVal("fiq_hold", 32'(nVICFIQ), 32'd0);
        @(negedge clk);
        checkVal("fiq_clear", 32'(nVICFIQ), 32'd1);
        VICFIQEn = 1'b0;
        busWrite(regAddr(12'h018), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVal("fiq_disabled", 32'(nVICFIQ), 32'd1);
        end
        busWrite(regAddr(12'h01C), 32'h1);
        VICFIQEn = 1'b1;
        busWrite(regAddr(12'h014), 32'h1);
        busWrite(regAddr(12'h00C), 32'h0);

        // Non-vectored source 9 and decode corners.
        busWrite(regAddr(12'h010), 32'h200);
        vic_intrsource[9] = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("nv_nirq", 32'(nVICIRQ), 32'd0);
        checkVal("nv_vect", VICVectAddrOut, 32'hDEF0);
        busRead(regAddr(12'h030), 32'hDEF0, "nv_ack");
        busRead(regAddr(12'h02C), 32'h10000, "nv_insvc");
        busRead(regAddr(12'h040), 32'h0, "unmapped_040");
        busRead(regAddr(12'h140), 32'h0, "vect16_oor");
        busRead(32'hFFFFE034, 32'h0, "unselected");
        busWrite(32'hFFFFE034, 32'h7777);
        busRead(regAddr(12'h034), 32'hDEF0, "unselected_wr_ignored");

        // Async reset while in service with slot 1 pending.
        vic_intrsource[1] = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("pre_rst_nirq", 32'(nVICIRQ), 32'd0);
        busRead(regAddr(12'h02C), 32'h10000, "pre_rst_insvc");
        #2;
        rst = 1'b0;
        #1;
        checkVal("arst_nirq", 32'(nVICIRQ), 32'd1);
        checkVal("arst_nfiq", 32'(nVICFIQ), 32'd1);
        checkVal("arst_vect", VICVectAddrOut, 32'h0);
        checkVal("arst_rdata", bus_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        vic_intrsource = '0;
        busRead(regAddr(12'h02C), 32'h0, "post_rst_insvc");
        busRead(regAddr(12'h010), 32'h0, "post_rst_enable");
        busRead(regAddr(12'h108), 32'h0, "post_rst_vect2");
        @(negedge clk);
        checkVal("rdq_drain", 32'(rdQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
